// File: rtl/sub_pipe_if.sv
// sub_pipe_if: operand/result handshake bundle for the sub_pipe subtractor.
//   in_valid/in_ready/a/b     producer -> subtractor (minuend a, subtrahend b)
//   out_valid/out_ready       subtractor -> consumer handshake
//   diff/borrow/overflow/zero/negative  registered result and flags
// master: the producer/consumer side; slave: the subtractor.
interface sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, overflow, zero, negative
  );
endinterface

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage pipelined subtractor, diff = a + ~b + 1.
//   Stage 1 adds the lower WIDTH/2 bits (carry-in 1) and registers the
//   half carry plus the upper operand halves; stage 2 finishes the upper
//   half with that carry and registers result and flags.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset; discards all in-flight ops
//   bus    sub_pipe_if.slave: in_valid/in_ready/a/b in,
//          out_valid/out_ready/diff/borrow/overflow/zero/negative out
// Flags: borrow = ~carry out (a < b unsigned); overflow = signed overflow;
// zero = diff == 0; negative = diff MSB. Outputs come straight from flops.

// 4-bit carry-lookahead group.
module sub_pipe_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

// Chain of CLA groups, group carries rippled. W must be a multiple of 4.
module sub_pipe_cla_chain #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  localparam int NG = W / 4;

  logic [NG:0] gc;
  assign gc[0] = c_i;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    sub_pipe_cla4 u_cla (
      .a_i (a_i[4*g +: 4]),
      .b_i (b_i[4*g +: 4]),
      .c_i (gc[g]),
      .s_o (s_o[4*g +: 4]),
      .c_o (gc[g+1])
    );
  end

  assign c_o = gc[NG];
endmodule

module sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sub_pipe_if.slave   bus
);
  localparam int HALF = WIDTH / 2;

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load, accept;

  // s2 takes s1's op when it is empty or its current op drains this cycle;
  // s1 can take a new op when empty or when its op moves on to s2.
  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    if (s2_load)            s2_valid_d = 1'b1;
    else if (bus.out_ready) s2_valid_d = 1'b0;
  end

  // ---------------- stage 1: lower half ----------------
  logic [HALF-1:0] lo_sum;
  logic            lo_carry;

  sub_pipe_cla_chain #(.W(HALF)) u_lo (
    .a_i (bus.a[HALF-1:0]),
    .b_i (~bus.b[HALF-1:0]),
    .c_i (1'b1),               // the +1 of two's-complement negation
    .s_o (lo_sum),
    .c_o (lo_carry)
  );

  logic [HALF-1:0] diff_lo_q, a_hi_q, nb_hi_q;
  logic            c_half_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      diff_lo_q  <= '0;
      a_hi_q     <= '0;
      nb_hi_q    <= '0;
      c_half_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      // data only moves on accept so X on idle inputs never enters the pipe
      if (accept) begin
        diff_lo_q <= lo_sum;
        a_hi_q    <= bus.a[WIDTH-1:HALF];
        nb_hi_q   <= ~bus.b[WIDTH-1:HALF];
        c_half_q  <= lo_carry;
      end
    end
  end

  // ---------------- stage 2: upper half + flags ----------------
  logic [HALF-1:0]  hi_sum;
  logic             hi_carry;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d, overflow_d, zero_d, negative_d;

  sub_pipe_cla_chain #(.W(HALF)) u_hi (
    .a_i (a_hi_q),
    .b_i (nb_hi_q),
    .c_i (c_half_q),
    .s_o (hi_sum),
    .c_o (hi_carry)
  );

  assign diff_d     = {hi_sum, diff_lo_q};
  assign borrow_d   = ~hi_carry;
  // a and b signs differ  <=>  a sign equals the inverted b sign
  assign overflow_d = (a_hi_q[HALF-1] == nb_hi_q[HALF-1]) &&
                      (hi_sum[HALF-1] != a_hi_q[HALF-1]);
  assign zero_d     = (diff_d == '0);
  assign negative_d = hi_sum[HALF-1];

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q, zero_q, negative_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      // result held while stalled: only s2_load replaces it
      if (s2_load) begin
        diff_q     <= diff_d;
        borrow_q   <= borrow_d;
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
        negative_q <= negative_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
endmodule
